biss_c_poll_ctrl: RTL and testbench

Polling scheduler for the `biss_c` master core. It issues periodic or single-shot position requests and supervises each frame with a watchdog. It classifies each outcome as good, CRC/frame failure or timeout, retries failed frames, and raises a sticky fault after repeated failures. It sits between the register/host side and `biss_c`, driving its `request` input and consuming its result and `state_debug` outputs.

---
 rtl/biss_c_pkg.sv | 20 ++
 rtl/biss_c_poll_timer.sv | 29 ++
 rtl/biss_c_poll_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_biss_c_poll_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biss_c_pkg.sv
// Shared types and helpers for the BiSS-C polling scheduler.
package biss_c_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BUSY  = 2'd2,
        S_DRAIN = 2'd3
    } poll_state_t;

    localparam logic [7:0] BISS_CORE_IDLE = 8'd0;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/biss_c_poll_timer.sv
// Free-running poll period counter; emits a one-cycle tick at the terminal count.
module biss_c_poll_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] poll_period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;
    logic                run;

    assign run = enable && (poll_period != '0);
    // >= rather than == so a period shortened below the current count still wraps.
    assign tick = run && (count >= poll_period - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/biss_c_poll_ctrl.sv
// Poll scheduler for the biss_c master: request issue, watchdog, retries, fault and statistics.
module biss_c_poll_ctrl
    import biss_c_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int WDOG_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                single_shot,
    input  logic [PERIOD_W-1:0] poll_period,
    input  logic [WDOG_W-1:0]   timeout_cycles,
    input  logic [3:0]          max_retries,
    input  logic                fault_clear,
    output logic                core_request,
    input  logic                core_valid,
    input  logic [31:0]         core_position,
    input  logic                core_error,
    input  logic                core_warn,
    input  logic [7:0]          core_state,
    output logic [31:0]         pos_data,
    output logic                pos_valid,
    output logic                pos_error,
    output logic                pos_warn,
    output logic [7:0]          seq,
    output logic                fault,
    output logic                busy,
    output logic [CNT_W-1:0]    ok_cnt,
    output logic [CNT_W-1:0]    crc_cnt,
    output logic [CNT_W-1:0]    tmo_cnt,
    output logic [CNT_W-1:0]    overrun_cnt,
    output logic [7:0]          state_dbg
);

    poll_state_t       state;
    logic              tick;
    logic              pending;
    logic              pending_ss;
    logic              ss_latched;
    logic              retry_wait;
    logic [3:0]        retry_cnt;
    logic [WDOG_W-1:0] wdog;
    logic              wdog_exp;
    logic              core_idle;
    logic              fail_crc;
    logic              fail_tmo;
    logic              can_retry;

    biss_c_poll_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .poll_period (poll_period),
        .tick        (tick)
    );

    // timeout_cycles = 0 wraps to all-ones here, giving the full 2^WDOG_W window.
    assign wdog_exp  = (wdog == timeout_cycles - WDOG_W'(1));
    assign core_idle = (core_state == BISS_CORE_IDLE);
    assign fail_crc  = (state == S_BUSY) && !core_valid && core_idle;
    assign fail_tmo  = wdog_exp && (((state == S_REQ) && core_idle) ||
                                    ((state == S_BUSY) && !core_valid && !core_idle));
    assign can_retry = (retry_cnt < max_retries) && (enable || ss_latched);
    assign busy      = (state != S_IDLE) || retry_wait;
    assign state_dbg = {6'd0, state};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            core_request <= 1'b0;
            pos_data     <= '0;
            pos_valid    <= 1'b0;
            pos_error    <= 1'b0;
            pos_warn     <= 1'b0;
            seq          <= '0;
            fault        <= 1'b0;
            ok_cnt       <= '0;
            crc_cnt      <= '0;
            tmo_cnt      <= '0;
            overrun_cnt  <= '0;
            pending      <= 1'b0;
            pending_ss   <= 1'b0;
            ss_latched   <= 1'b0;
            retry_wait   <= 1'b0;
            retry_cnt    <= '0;
            wdog         <= '0;
        end else begin
            pos_valid <= 1'b0;
            if (fault_clear) fault <= 1'b0;
            if (state != S_IDLE) wdog <= wdog + WDOG_W'(1);

            // Ticks landing on an outstanding request or active frame are merged and only counted.
            if (tick && (pending || busy)) overrun_cnt <= CNT_W'(sat_inc(32'(overrun_cnt), CNT_W));
            if (single_shot) begin
                pending    <= 1'b1;
                pending_ss <= 1'b1;
            end else if (tick && !busy) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (retry_wait) begin
                        if (core_idle) begin
                            retry_wait   <= 1'b0;
                            state        <= S_REQ;
                            core_request <= 1'b1;
                            wdog         <= '0;
                            pending      <= 1'b0;
                            pending_ss   <= 1'b0;
                            ss_latched   <= ss_latched || pending_ss;
                        end
                    end else if (pending || tick || single_shot) begin
                        state        <= S_REQ;
                        core_request <= 1'b1;
                        wdog         <= '0;
                        retry_cnt    <= '0;
                        pending      <= 1'b0;
                        pending_ss   <= 1'b0;
                        ss_latched   <= pending_ss || single_shot;
                    end
                end
                S_REQ: begin
                    if (!core_idle) begin
                        state        <= S_BUSY;
                        core_request <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (core_valid) begin
                        pos_data  <= core_position;
                        pos_error <= ~core_error;
                        pos_warn  <= ~core_warn;
                        pos_valid <= 1'b1;
                        seq       <= seq + 8'd1;
                        ok_cnt    <= CNT_W'(sat_inc(32'(ok_cnt), CNT_W));
                        retry_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (core_idle) begin
                        state <= S_IDLE;
                    end else if (wdog_exp) begin
                        tmo_cnt <= CNT_W'(sat_inc(32'(tmo_cnt), CNT_W));
                        fault   <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (fail_crc || fail_tmo) begin
                core_request <= 1'b0;
                if (fail_crc) crc_cnt <= CNT_W'(sat_inc(32'(crc_cnt), CNT_W));
                else          tmo_cnt <= CNT_W'(sat_inc(32'(tmo_cnt), CNT_W));
                if (can_retry) begin
                    retry_cnt <= retry_cnt + 4'd1;
                    if (fail_crc) begin
                        state        <= S_REQ;
                        core_request <= 1'b1;
                        wdog         <= '0;
                        pending      <= 1'b0;
                        pending_ss   <= 1'b0;
                        ss_latched   <= ss_latched || pending_ss;
                    end else begin
                        // Drop the request for at least a cycle and wait for the core to go idle.
                        state      <= S_IDLE;
                        retry_wait <= 1'b1;
                    end
                end else begin
                    fault     <= 1'b1;
                    retry_cnt <= '0;
                    state     <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_biss_c_poll_ctrl.sv
// Directed bench for biss_c_poll_ctrl with a behavioural biss_c core stand-in.
module tb_biss_c_poll_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic [23:0] poll_period = '0;
    logic [15:0] timeout_cycles = 16'd1000;
    logic [3:0]  max_retries = 4'd2;
    logic        fault_clear = 1'b0;
    logic        core_request;
    logic        core_valid = 1'b0;
    logic [31:0] core_position = '0;
    logic        core_error = 1'b1;
    logic        core_warn = 1'b1;
    logic [7:0]  core_state = '0;
    logic [31:0] pos_data;
    logic        pos_valid;
    logic        pos_error;
    logic        pos_warn;
    logic [7:0]  seq;
    logic        fault;
    logic        busy;
    logic [15:0] ok_cnt;
    logic [15:0] crc_cnt;
    logic [15:0] tmo_cnt;
    logic [15:0] overrun_cnt;
    logic [7:0]  state_dbg;

    biss_c_poll_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .single_shot    (single_shot),
        .poll_period    (poll_period),
        .timeout_cycles (timeout_cycles),
        .max_retries    (max_retries),
        .fault_clear    (fault_clear),
        .core_request   (core_request),
        .core_valid     (core_valid),
        .core_position  (core_position),
        .core_error     (core_error),
        .core_warn      (core_warn),
        .core_state     (core_state),
        .pos_data       (pos_data),
        .pos_valid      (pos_valid),
        .pos_error      (pos_error),
        .pos_warn       (pos_warn),
        .seq            (seq),
        .fault          (fault),
        .busy           (busy),
        .ok_cnt         (ok_cnt),
        .crc_cnt        (crc_cnt),
        .tmo_cnt        (tmo_cnt),
        .overrun_cnt    (overrun_cnt),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Core stand-in settings, written by the main sequence.
    logic        core_silent = 1'b0;
    logic        crc_once = 1'b0;
    int          frame_len = 20;
    logic [31:0] frame_pos = '0;
    logic        frame_ne = 1'b1;
    logic        frame_nw = 1'b1;

    // Observations sampled just after each rising edge.
    int   cyc = 0;
    int   req_rises = 0;
    int   pv_count = 0;
    logic prev_req = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (core_request && !prev_req) req_rises++;
            prev_req = core_request;
            if (pos_valid) pv_count++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (core_request && !core_silent && core_state == 8'd0) begin
                core_state = 8'd1;
                repeat (frame_len) @(negedge clk);
                if (crc_once) begin
                    crc_once   = 1'b0;
                    core_state = 8'd0;
                end else begin
                    core_valid    = 1'b1;
                    core_position = frame_pos;
                    core_error    = frame_ne;
                    core_warn     = frame_nw;
                    @(negedge clk);
                    core_valid = 1'b0;
                    core_state = 8'd0;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_pv(input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!pos_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(pos_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_single_shot();
        @(negedge clk);
        single_shot = 1'b1;
        @(negedge clk);
        single_shot = 1'b0;
    endtask

    initial begin
        int t1, t2, base_ovr, base_req, base_pv, base_crc, base_tmo;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_core_request", 32'(core_request), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_outputs", {pos_data}, 32'd0);
        check("rst_flags", {28'd0, pos_valid, fault, busy, pos_error}, 32'd0);
        check("rst_counters", {ok_cnt, tmo_cnt}, 32'd0);
        rst = 1'b1;

        // Periodic polling, good frames with nE = nW = 1
        frame_len   = 20;
        frame_pos   = 32'hE5DF5C3E;
        frame_ne    = 1'b1;
        frame_nw    = 1'b1;
        @(negedge clk);
        poll_period = 24'd2000;
        enable      = 1'b1;
        wait_pv(2500, "periodic_pv1");
        t1 = cyc;
        check("periodic_pos1", pos_data, 32'hE5DF5C3E);
        check("periodic_err1", {30'd0, pos_error, pos_warn}, 32'd0);
        check("periodic_seq1", 32'(seq), 32'd1);
        wait_pv(2500, "periodic_pv2");
        t2 = cyc;
        check("periodic_interval", 32'(t2 - t1), 32'd2000);
        check("periodic_seq2", 32'(seq), 32'd2);
        wait_pv(2500, "periodic_pv3");
        check("periodic_seq3", 32'(seq), 32'd3);
        check("periodic_ok_cnt", 32'(ok_cnt), 32'd3);
        enable      = 1'b0;
        poll_period = '0;
        wait_idle(200, "periodic_idle");
        check("periodic_req_rises", 32'(req_rises), 32'd3);
        check("periodic_no_overrun", 32'(overrun_cnt), 32'd0);

        // Overrun: 100-cycle period against ~285-cycle frames
        base_ovr    = 32'(overrun_cnt);
        base_req    = req_rises;
        frame_len   = 280;
        frame_pos   = 32'hA5A5_0001;
        poll_period = 24'd100;
        enable      = 1'b1;
        wait_pv(400, "overrun_pv1");
        wait_pv(400, "overrun_pv2");
        enable      = 1'b0;
        poll_period = '0;
        wait_idle(200, "overrun_idle");
        check("overrun_cnt_delta", 32'(overrun_cnt) - 32'(base_ovr), 32'd4);
        check("overrun_req_delta", 32'(req_rises - base_req), 32'd2);
        check("overrun_ok_cnt", 32'(ok_cnt), 32'd5);

        // CRC failure once, then a good frame on retry
        frame_len = 20;
        frame_pos = 32'h1234_5678;
        base_pv   = pv_count;
        base_crc  = 32'(crc_cnt);
        crc_once  = 1'b1;
        pulse_single_shot();
        wait_pv(200, "crc_pv");
        wait_idle(200, "crc_idle");
        check("crc_cnt_delta", 32'(crc_cnt) - 32'(base_crc), 32'd1);
        check("crc_ok_cnt", 32'(ok_cnt), 32'd6);
        check("crc_fault", 32'(fault), 32'd0);
        check("crc_pos", pos_data, 32'h1234_5678);
        check("crc_pv_once", 32'(pv_count - base_pv), 32'd1);

        // Single shot with encoder error and warning asserted (nE = nW = 0)
        frame_pos = 32'h0BAD_F00D;
        frame_ne  = 1'b0;
        frame_nw  = 1'b0;
        base_req  = req_rises;
        base_pv   = pv_count;
        pulse_single_shot();
        wait_pv(200, "ss_pv");
        check("ss_flags", {30'd0, pos_error, pos_warn}, 32'd3);
        check("ss_pos", pos_data, 32'h0BAD_F00D);
        check("ss_seq", 32'(seq), 32'd7);
        repeat (200) @(negedge clk);
        check("ss_req_once", 32'(req_rises - base_req), 32'd1);
        check("ss_pv_once", 32'(pv_count - base_pv), 32'd1);
        check("ss_state_idle", 32'(state_dbg), 32'd0);

        // Silent slave: three timed-out attempts then a sticky fault
        core_silent    = 1'b1;
        timeout_cycles = 16'd500;
        max_retries    = 4'd2;
        base_tmo       = 32'(tmo_cnt);
        base_req       = req_rises;
        pulse_single_shot();
        repeat (700) @(negedge clk);
        check("silent_tmo_after_1", 32'(tmo_cnt) - 32'(base_tmo), 32'd1);
        check("silent_no_fault_yet", 32'(fault), 32'd0);
        begin
            int n;
            n = 0;
            while (!fault && n < 1500) begin
                @(negedge clk);
                n++;
            end
        end
        check("silent_fault", 32'(fault), 32'd1);
        check("silent_tmo_total", 32'(tmo_cnt) - 32'(base_tmo), 32'd3);
        check("silent_attempts", 32'(req_rises - base_req), 32'd3);
        check("silent_state_idle", {24'd0, state_dbg}, 32'd0);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check("fault_clear", 32'(fault), 32'd0);

        // Reset while a frame is in S_BUSY
        core_silent    = 1'b0;
        timeout_cycles = 16'd1000;
        frame_len      = 50;
        pulse_single_shot();
        begin
            int n;
            n = 0;
            while (state_dbg != 8'd2 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("midframe_in_busy", 32'(state_dbg), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("midframe_core_request", 32'(core_request), 32'd0);
        check("midframe_state", 32'(state_dbg), 32'd0);
        check("midframe_cnts_a", {ok_cnt, crc_cnt}, 32'd0);
        check("midframe_cnts_b", {tmo_cnt, overrun_cnt}, 32'd0);
        check("midframe_outputs", pos_data, 32'd0);
        check("midframe_flags", {20'd0, seq, pos_valid, fault, busy, pos_error}, 32'd0);
        rst = 1'b1;
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
